uart_line_buffer: RTL and testbench
===================================

Name: uart_line_buffer

Overview:
- Line-assembly stage between the RX/case-conversion path and the TX FIFO/transmitter.
- Collects received bytes into an internal line buffer and applies backspace editing.
- On carriage return, emits the completed line followed by CR LF as a valid/ready byte stream.
- Lets the TX side send whole edited lines, never partial keystrokes.

Parameters:
DEPTH, 32, line buffer capacity in bytes; power of two, >= 4.
LW, $clog2(DEPTH)+1, local: width of the length counter, range 0..DEPTH.

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_data  input  8  received byte; qualified by i_valid
i_valid  input  1  single-cycle strobe; no backpressure on this side
o_data  output  8  byte to transmitter; stable while o_valid=1 and i_ready=0
o_valid  output  1  o_data holds a byte
i_ready  input  1  downstream accepts; transfer occurs when o_valid & i_ready
o_busy  output  1  1 while a line is being emitted (any state other than COLLECT)
o_len  output  LW  current number of buffered characters
o_overflow  output  1  sticky; set when a printable byte is dropped because the buffer is full
o_drop  output  1  one-cycle pulse when an input byte is discarded because o_busy=1

Behaviour:
- Reset (asynchronous, i_rst_n=0): all outputs and state clear immediately.
  - State=COLLECT; o_valid=0, o_data=0x00, o_len=0, o_overflow=0, o_drop=0, o_busy=0.
  - Buffer contents are don't-care.
  - Reset in mid-flush abandons the line; no further output bytes.
- States: COLLECT, FLUSH, SEND_CR, SEND_LF. All outputs are registered.
- COLLECT, on i_valid:
  - 0x0D (CR): go to FLUSH if o_len>0, otherwise go to SEND_CR.
    - Next cycle: o_valid=1, o_data=buf[0] (or 0x0D for an empty line).
  - 0x08 or 0x7F (backspace): o_len decrements if >0; ignored at 0.
  - 0x0A (LF): ignored, so CRLF-sending terminals do not produce blank lines.
  - Any other byte, o_len<DEPTH: buf[o_len] <= i_data; o_len increments.
  - Any other byte, o_len==DEPTH: byte dropped; o_overflow <= 1.
- FLUSH:
  - Read index rd starts at 0; o_data=buf[rd].
  - On each transfer, rd increments.
  - If the transferred byte was index o_len-1, load 0x0D and go to SEND_CR without dropping o_valid.
  - Back-to-back transfers are permitted: with i_ready held high, one byte per cycle.
- SEND_CR: on transfer, load 0x0A and go to SEND_LF.
- SEND_LF: on transfer, clear o_valid, o_len=0, rd=0 and o_overflow=0, and return to COLLECT.
  - The return takes effect the same cycle; a byte arriving on the following cycle is accepted.
- While o_busy=1, every i_valid byte (CR included) is discarded and o_drop pulses for 1 cycle.
- o_valid never deasserts without a transfer, except on reset; o_data never changes while o_valid=1 and i_ready=0.
- Bytes are stored verbatim; no conversion happens in this block.
- Total emitted bytes per line = o_len + 2.

Test Plan:
- Send "AB", CR with i_ready=1 -> o_data sequence 0x41, 0x42, 0x0D, 0x0A.
  - o_valid first high the cycle after CR; 4 consecutive transfer cycles; then o_busy=0, o_len=0.
- Send "ABX", 0x08, "C", CR -> emitted 0x41, 0x42, 0x43, 0x0D, 0x0A.
  - Also: 0x08 with o_len=0 leaves o_len=0.
- Send a bare CR, then LF -> exactly 0x0D, 0x0A emitted.
  - The LF input is ignored; no second line.
- DEPTH=32: send 34 printable bytes then CR.
  - o_overflow=1 after byte 33 and o_len=32; 32 bytes + CR LF emitted; o_overflow=0 after the LF transfer.
- During a flush, toggle i_ready randomly and inject "Z" -> o_drop pulses once, "Z" is not emitted, o_data is stable across every stall cycle.
- Assert i_rst_n=0 mid-FLUSH after 2 of 5 bytes -> o_valid=0 and o_busy=0 asynchronously.
  - After release, "Q", CR yields 0x51, 0x0D, 0x0A only.

Source files
------------

// File: rtl/uart_line_buffer.sv
// Line-assembly stage: buffers received bytes with backspace editing and, on CR,
// emits the edited line followed by CR LF as a valid/ready byte stream.
module uart_line_buffer #(
   parameter int DEPTH = 32,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [7:0]    i_data,
   input  logic          i_valid,
   output logic [7:0]    o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_busy,
   output logic [LW-1:0] o_len,
   output logic          o_overflow,
   output logic          o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [1:0] {COLLECT, FLUSH, SEND_CR, SEND_LF} state_t;

   state_t          state, state_n;
   logic [7:0]      line_mem [DEPTH];
   logic [AW-1:0]   rd, rd_n, rd_inc;
   logic [LW-1:0]   len_n;
   logic [7:0]      data_n;
   logic            valid_n, ovf_n, drop_n, busy_n, wr_en;
   logic            xfer, last_byte;

   assign xfer      = o_valid & i_ready;
   assign rd_inc    = rd + AW'(1);
   assign last_byte = ({1'b0, rd} == (o_len - LW'(1)));

   always_comb begin
      state_n = state;
      rd_n    = rd;
      len_n   = o_len;
      data_n  = o_data;
      valid_n = o_valid;
      ovf_n   = o_overflow;
      drop_n  = 1'b0;
      wr_en   = 1'b0;
      unique case (state)
         COLLECT: begin
            if (i_valid) begin
               unique case (i_data)
                  8'h0D: begin
                     valid_n = 1'b1;
                     rd_n    = '0;
                     if (o_len != '0) begin
                        state_n = FLUSH;
                        data_n  = line_mem[0];
                     end else begin
                        state_n = SEND_CR;
                        data_n  = 8'h0D;
                     end
                  end
                  8'h08, 8'h7F: begin
                     if (o_len != '0) len_n = o_len - LW'(1);
                  end
                  8'h0A: ;
                  default: begin
                     if (o_len < FULL) begin
                        wr_en = 1'b1;
                        len_n = o_len + LW'(1);
                     end else begin
                        ovf_n = 1'b1;
                     end
                  end
               endcase
            end
         end
         FLUSH: begin
            drop_n = i_valid;
            if (xfer) begin
               if (last_byte) begin
                  state_n = SEND_CR;
                  data_n  = 8'h0D;
               end else begin
                  rd_n   = rd_inc;
                  data_n = line_mem[rd_inc];
               end
            end
         end
         SEND_CR: begin
            drop_n = i_valid;
            if (xfer) begin
               state_n = SEND_LF;
               data_n  = 8'h0A;
            end
         end
         SEND_LF: begin
            drop_n = i_valid;
            if (xfer) begin
               state_n = COLLECT;
               valid_n = 1'b0;
               len_n   = '0;
               rd_n    = '0;
               ovf_n   = 1'b0;
            end
         end
         default: state_n = COLLECT;
      endcase
      busy_n = (state_n != COLLECT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= COLLECT;
         rd         <= '0;
         o_len      <= '0;
         o_data     <= 8'h00;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
         o_drop     <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         state      <= state_n;
         rd         <= rd_n;
         o_len      <= len_n;
         o_data     <= data_n;
         o_valid    <= valid_n;
         o_overflow <= ovf_n;
         o_drop     <= drop_n;
         o_busy     <= busy_n;
      end
   end

   // Buffer storage carries no reset; stale contents beyond o_len are never read.
   always_ff @(posedge i_clk) begin
      if (wr_en) line_mem[o_len[AW-1:0]] <= i_data;
   end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Scoreboard bench for uart_line_buffer: stimulus pushes expected output bytes,
// a negedge monitor pops and compares each transfer and checks stall stability.
module tb_uart_line_buffer;

   localparam int DEPTH = 32;
   localparam int LW = $clog2(DEPTH) + 1;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [7:0]    i_data = 8'h00;
   logic          i_valid = 1'b0;
   logic [7:0]    o_data;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic          o_busy;
   logic [LW-1:0] o_len;
   logic          o_overflow;
   logic          o_drop;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   uart_line_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
      .o_len(o_len), .o_overflow(o_overflow), .o_drop(o_drop)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_data  = b;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || o_busy) && n < 400) begin
         tick();
         n++;
      end
      check({name, "_idle_timeout"}, (n < 400) ? 1 : 0, 1);
   endtask

   // Monitor: a transfer seen at negedge completes on the next rising edge.
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", int'(o_valid), 1);
            check("stall_data", int'(o_data), int'(stall_data));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got 0x%0h, expected none", o_data);
            end else begin
               check("out_byte", int'(o_data), int'(exp_q.pop_front()));
            end
         end
         stall_prev = o_valid && !i_ready;
         stall_data = o_data;
      end
   end

   initial begin
      int drop_cnt;
      string s;

      // Reset state
      #3;
      check("rst_valid", int'(o_valid), 0);
      check("rst_data", int'(o_data), 0);
      check("rst_len", int'(o_len), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_ovf", int'(o_overflow), 0);
      check("rst_drop", int'(o_drop), 0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();

      // "AB" CR, back-to-back transfers
      i_ready = 1'b1;
      send_byte(8'h41);
      send_byte(8'h42);
      check("ab_len", int'(o_len), 2);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      check("ab_first_valid", int'(o_valid), 1);
      check("ab_first_data", int'(o_data), 8'h41);
      check("ab_busy", int'(o_busy), 1);
      repeat (4) tick();
      check("ab_done_busy", int'(o_busy), 0);
      check("ab_done_valid", int'(o_valid), 0);
      check("ab_done_len", int'(o_len), 0);
      check("ab_queue_empty", exp_q.size(), 0);

      // Backspace editing
      send_byte(8'h08);
      check("bs_at_zero", int'(o_len), 0);
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h58);
      send_byte(8'h08);
      check("bs_len", int'(o_len), 2);
      send_byte(8'h43);
      send_byte(8'h7F); send_byte(8'h43);
      check("bs_len2", int'(o_len), 3);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      wait_idle("bs");

      // Bare CR then LF
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      check("cr_first_data", int'(o_data), 8'h0D);
      check("cr_first_valid", int'(o_valid), 1);
      wait_idle("cr");
      send_byte(8'h0A);
      repeat (3) tick();
      check("lf_ignored_valid", int'(o_valid), 0);
      check("lf_ignored_len", int'(o_len), 0);

      // Overflow: 34 printable bytes into a 32-byte buffer
      for (int i = 0; i < 34; i++) begin
         send_byte(8'h20 + 8'(i));
         if (i < 32) exp_q.push_back(8'h20 + 8'(i));
         if (i == 31) check("ovf_before", int'(o_overflow), 0);
         if (i == 32) begin
            check("ovf_set", int'(o_overflow), 1);
            check("ovf_len", int'(o_len), 32);
         end
      end
      check("ovf_len_final", int'(o_len), 32);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      wait_idle("ovf");
      check("ovf_cleared", int'(o_overflow), 0);

      // Random backpressure with an injected byte during flush
      i_ready = 1'b0;
      s = "HELLO";
      for (int i = 0; i < 5; i++) begin
         send_byte(s[i]);
         exp_q.push_back(s[i]);
      end
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      drop_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         i_ready = 1'($urandom_range(0, 1));
         if (k == 3) begin
            i_data  = 8'h5A;
            i_valid = 1'b1;
         end
         tick();
         i_valid = 1'b0;
         if (k == 3) check("drop_pulse", int'(o_drop), 1);
         drop_cnt += int'(o_drop);
      end
      check("drop_once", drop_cnt, 1);
      i_ready = 1'b1;
      wait_idle("stall");

      // Reset in mid-flush after 2 of 5 bytes
      s = "12345";
      for (int i = 0; i < 5; i++) begin
         send_byte(s[i]);
         exp_q.push_back(s[i]);
      end
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h0D);
      tick();
      tick();
      i_ready = 1'b0;
      check("pre_rst_data", int'(o_data), 8'h33);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_valid", int'(o_valid), 0);
      check("arst_busy", int'(o_busy), 0);
      check("arst_len", int'(o_len), 0);
      exp_q.delete();
      tick();
      tick();
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      tick();
      exp_q.push_back(8'h51); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_byte(8'h51);
      send_byte(8'h0D);
      wait_idle("post_rst");
      repeat (3) tick();
      check("post_rst_valid", int'(o_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
